// File: rtl/flac_pkg.sv
// Types and constants shared by the FLAC fixed-predictor encoder and decoder:
// FSM state encoding, predictor order and Rice parameter limits.
package flac_pkg;

    localparam int SAMPLE_W_DEF = 16;
    localparam int RES_W_DEF    = 21;

    localparam logic [2:0] ORDER_MAX = 3'd4;
    localparam logic [3:0] RICE_MAX  = 4'd14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_PREDICT,
        ST_UNARY,
        ST_BINARY,
        ST_FLUSH,
        ST_DONE
    } enc_state_e;

    function automatic logic [2:0] clamp_order(input logic [2:0] order);
        return (order > ORDER_MAX) ? ORDER_MAX : order;
    endfunction

    function automatic logic [3:0] clamp_rice(input logic [3:0] k);
        return (k > RICE_MAX) ? RICE_MAX : k;
    endfunction

endpackage

// File: rtl/fixed_residual_encoder_if.sv
// Sample input / RAM write bus of the fixed-residual encoder; the host drives
// the master side, the encoder sits on the slave side.
interface fixed_residual_encoder_if #(
    parameter int SAMPLE_W = 16,
    parameter int ADDR_W   = 16
);
    logic                iEnable;
    logic                iStart;
    logic [2:0]          iOrder;
    logic [3:0]          iRiceParam;
    logic [15:0]         iBlockSize;
    logic [SAMPLE_W-1:0] iSample;
    logic                iSampleValid;
    logic                oSampleReady;
    logic [15:0]         oWriteData;
    logic [ADDR_W-1:0]   oWriteAddr;
    logic                oWriteEnable;
    logic                oDone;

    modport master (
        output iEnable, iStart, iOrder, iRiceParam, iBlockSize, iSample, iSampleValid,
        input  oSampleReady, oWriteData, oWriteAddr, oWriteEnable, oDone
    );

    modport slave (
        input  iEnable, iStart, iOrder, iRiceParam, iBlockSize, iSample, iSampleValid,
        output oSampleReady, oWriteData, oWriteAddr, oWriteEnable, oDone
    );
endinterface

// File: rtl/rice_bit_packer.sv
// MSB-first bit packer: appends up to 16 bits per cycle to a left-justified
// 32-bit accumulator and releases a 16-bit word whenever one is complete.
module rice_bit_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] bits,
    input  logic [4:0]  len,
    input  logic        valid,
    input  logic        flush,
    output logic [15:0] word,
    output logic        word_valid,
    output logic        drain_pending,
    output logic        empty_after
);
    logic [31:0] acc_q, acc_d;
    logic [5:0]  fill_q, fill_d;
    logic [5:0]  fill_after;
    logic [5:0]  shamt;

    // At most 16 bits arrive per cycle and 16 leave whenever fill >= 16,
    // so the fill never exceeds 31 and one word per cycle always keeps up.
    assign drain_pending = (fill_q >= 6'd16);
    assign word_valid    = en && (drain_pending || (flush && fill_q != 6'd0));
    assign word          = acc_q[31:16];
    assign fill_after    = word_valid ? (drain_pending ? fill_q - 6'd16 : 6'd0) : fill_q;
    assign empty_after   = (fill_after == 6'd0);
    assign shamt         = 6'd32 - fill_after - {1'b0, len};

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        acc_d  = word_valid ? {acc_q[15:0], 16'h0000} : acc_q;
        fill_d = fill_after;
        if (valid && len != 5'd0) begin
            acc_d  = acc_d | ({16'h0000, bits} << shamt);
            fill_d = fill_after + {1'b0, len};
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            fill_q <= '0;
        end else if (en) begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/fixed_residual_encoder.sv
// FLAC fixed-predictor encoder: writes warm-up samples verbatim, then the
// Rice-coded residuals of the remaining samples as packed 16-bit RAM words.
module fixed_residual_encoder
    import flac_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int ADDR_W   = 16,
    parameter int RES_W    = RES_W_DEF
) (
    input logic                      iClock,
    input logic                      iReset,
    fixed_residual_encoder_if.slave  bus
);
    enc_state_e                 state_q, state_d;
    logic [2:0]                 order_q, order_d;
    logic [3:0]                 k_q, k_d;
    logic [15:0]                bsize_q, bsize_d;
    logic [15:0]                cnt_q, cnt_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic signed [SAMPLE_W-1:0] hist_q [4];
    logic signed [SAMPLE_W-1:0] hist_d [4];
    logic [RES_W:0]             q_rem_q, q_rem_d;
    logic [15:0]                b_q, b_d;
    logic                       we_q, we_d;
    logic [15:0]                wdata_q, wdata_d;
    logic [ADDR_W-1:0]          waddr_q, waddr_d;
    logic                       done_q, done_d;
    logic                       sample_ready;

    logic signed [RES_W-1:0] h1, h2, h3, h4, x_ext, pred, res;
    logic [RES_W:0]          u_val, q_val, q_left;
    logic [15:0]             b_val;
    logic [4:0]              emit;
    logic [15:0]             cnt_next;
    logic [ADDR_W-1:0]       addr_next;

    logic [15:0] pk_bits, pk_word;
    logic [4:0]  pk_len;
    logic        pk_valid, pk_flush, pk_word_valid, pk_drain_pending, pk_empty_after;

    assign h1    = RES_W'(hist_q[0]);
    assign h2    = RES_W'(hist_q[1]);
    assign h3    = RES_W'(hist_q[2]);
    assign h4    = RES_W'(hist_q[3]);
    assign x_ext = RES_W'($signed(bus.iSample));

    always_comb begin
        case (order_q)
            3'd0:    pred = '0;
            3'd1:    pred = h1;
            3'd2:    pred = (h1 <<< 1) - h2;
            3'd3:    pred = (h1 <<< 1) + h1 - (h2 <<< 1) - h2 + h3;
            default: pred = (h1 <<< 2) - (h2 <<< 2) - (h2 <<< 1) + (h3 <<< 2) - h4;
        endcase
    end

    // Zigzag folds the sign into the LSB: r >= 0 -> 2r, r < 0 -> -2r-1.
    assign res       = x_ext - pred;
    assign u_val     = {res, 1'b0} ^ {(RES_W + 1){res[RES_W-1]}};
    assign q_val     = u_val >> k_q;
    assign b_val     = u_val[15:0] & ((16'd1 << k_q) - 16'd1);
    assign emit      = (q_rem_q > (RES_W + 1)'(16)) ? 5'd16 : q_rem_q[4:0];
    assign q_left    = q_rem_q - {{(RES_W - 4){1'b0}}, emit};
    assign cnt_next  = cnt_q + 16'd1;
    assign addr_next = addr_q + ADDR_W'(1);
    assign pk_flush  = bus.iEnable && (state_q == ST_FLUSH);

    rice_bit_packer u_packer (
        .clk           (iClock),
        .rst_n         (iReset),
        .en            (bus.iEnable),
        .bits          (pk_bits),
        .len           (pk_len),
        .valid         (pk_valid),
        .flush         (pk_flush),
        .word          (pk_word),
        .word_valid    (pk_word_valid),
        .drain_pending (pk_drain_pending),
        .empty_after   (pk_empty_after)
    );

    always_comb begin
        state_d      = state_q;
        order_d      = order_q;
        k_d          = k_q;
        bsize_d      = bsize_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        hist_d       = hist_q;
        q_rem_d      = q_rem_q;
        b_d          = b_q;
        we_d         = 1'b0;
        wdata_d      = wdata_q;
        waddr_d      = waddr_q;
        done_d       = 1'b0;
        sample_ready = 1'b0;
        pk_bits      = '0;
        pk_len       = '0;
        pk_valid     = 1'b0;

        if (!bus.iEnable) begin
            // Hold a pending write/done strobe; the outputs gate it until resume.
            we_d   = we_q;
            done_d = done_q;
        end else begin
            if (pk_word_valid) begin
                we_d    = 1'b1;
                wdata_d = pk_word;
                waddr_d = addr_q;
                addr_d  = addr_next;
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.iStart) begin
                        order_d = clamp_order(bus.iOrder);
                        k_d     = clamp_rice(bus.iRiceParam);
                        bsize_d = bus.iBlockSize;
                        cnt_d   = '0;
                        addr_d  = '0;
                        hist_d  = '{default: '0};
                        state_d = (clamp_order(bus.iOrder) != 3'd0) ? ST_WARMUP : ST_PREDICT;
                    end
                end
                ST_WARMUP: begin
                    sample_ready = 1'b1;
                    if (bus.iSampleValid) begin
                        we_d    = 1'b1;
                        wdata_d = bus.iSample;
                        waddr_d = addr_q;
                        addr_d  = addr_next;
                        hist_d  = '{bus.iSample, hist_q[0], hist_q[1], hist_q[2]};
                        cnt_d   = cnt_next;
                        if (cnt_next == {13'd0, order_q})
                            state_d = (cnt_next == bsize_q) ? ST_FLUSH : ST_PREDICT;
                    end
                end
                ST_PREDICT: begin
                    sample_ready = !pk_drain_pending;
                    if (sample_ready && bus.iSampleValid) begin
                        hist_d  = '{bus.iSample, hist_q[0], hist_q[1], hist_q[2]};
                        q_rem_d = q_val;
                        b_d     = b_val;
                        state_d = ST_UNARY;
                    end
                end
                ST_UNARY: begin
                    pk_valid = 1'b1;
                    pk_len   = emit;
                    q_rem_d  = q_left;
                    if (q_left == '0)
                        state_d = ST_BINARY;
                end
                ST_BINARY: begin
                    pk_valid = 1'b1;
                    pk_bits  = (16'd1 << k_q) | b_q;
                    pk_len   = {1'b0, k_q} + 5'd1;
                    cnt_d    = cnt_next;
                    state_d  = (cnt_next == bsize_q) ? ST_FLUSH : ST_PREDICT;
                end
                ST_FLUSH: begin
                    if (pk_empty_after)
                        state_d = ST_DONE;
                end
                ST_DONE: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: the four-entry history is prediction state, not storage, so it is
    // cleared by reset like every other flop.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q <= ST_IDLE;
            order_q <= '0;
            k_q     <= '0;
            bsize_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            hist_q  <= '{default: '0};
            q_rem_q <= '0;
            b_q     <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            waddr_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            order_q <= order_d;
            k_q     <= k_d;
            bsize_q <= bsize_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            hist_q  <= hist_d;
            q_rem_q <= q_rem_d;
            b_q     <= b_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
            done_q  <= done_d;
        end
    end

    assign bus.oSampleReady = sample_ready;
    assign bus.oWriteEnable = we_q && bus.iEnable;
    assign bus.oWriteData   = wdata_q;
    assign bus.oWriteAddr   = waddr_q;
    assign bus.oDone        = done_q && bus.iEnable;

endmodule

// File: tb/tb_fixed_residual_encoder.sv
// Directed scoreboard bench for fixed_residual_encoder: the driver queues the
// hand-computed RAM writes, a negedge monitor pops and compares each write.
module tb_fixed_residual_encoder;
    import flac_pkg::*;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    wr_t  exp_q[$];

    always #5 clk = ~clk;

    fixed_residual_encoder_if #(.SAMPLE_W(16), .ADDR_W(16)) bus ();

    fixed_residual_encoder dut (
        .iClock (clk),
        .iReset (rst_n),
        .bus    (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_exp(input logic [15:0] addr, input logic [15:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: one RAM write per cycle with oWriteEnable high.
    always @(negedge clk) begin
        if (rst_n && bus.oWriteEnable) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                         bus.oWriteAddr, bus.oWriteData);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 32'(bus.oWriteAddr), 32'(e.addr));
                check("write_data", 32'(bus.oWriteData), 32'(e.data));
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, 32'(bus.oSampleReady), 32'd0);
        check({tag, "_we"},    32'(bus.oWriteEnable), 32'd0);
        check({tag, "_wdata"}, 32'(bus.oWriteData),   32'd0);
        check({tag, "_waddr"}, 32'(bus.oWriteAddr),   32'd0);
        check({tag, "_done"},  32'(bus.oDone),        32'd0);
    endtask

    task automatic start_block(input logic [2:0] order, input logic [3:0] k, input logic [15:0] bs);
        @(posedge clk); #1;
        bus.iStart     = 1'b1;
        bus.iOrder     = order;
        bus.iRiceParam = k;
        bus.iBlockSize = bs;
        @(posedge clk); #1;
        bus.iStart = 1'b0;
    endtask

    task automatic send_sample(input logic [15:0] s);
        bit accepted = 0;
        bus.iSample      = s;
        bus.iSampleValid = 1'b1;
        for (int c = 0; c < 100 && !accepted; c++) begin
            @(negedge clk);
            if (bus.oSampleReady) begin
                @(posedge clk); #1;
                accepted = 1;
            end
        end
        bus.iSampleValid = 1'b0;
        if (!accepted) check("sample_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int c = 0; c < 500 && !seen; c++) begin
            @(negedge clk);
            if (bus.oDone) seen = 1;
        end
        check("done_seen", 32'(seen), 32'd1);
        check("writes_drained_at_done", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check("done_is_pulse", 32'(bus.oDone), 32'd0);
    endtask

    task automatic push_order4_image();
        push_exp(16'd0, 16'h8000);
        push_exp(16'd1, 16'h7FFF);
        push_exp(16'd2, 16'h8000);
        push_exp(16'd3, 16'h7FFF);
        push_exp(16'd4, 16'h0000);
        push_exp(16'd5, 16'h0000);
        push_exp(16'd6, 16'h0000);
        push_exp(16'd7, 16'h0001);
        push_exp(16'd8, 16'hFFBC);
    endtask

    task automatic send_order4_samples();
        send_sample(16'h8000);
        send_sample(16'h7FFF);
        send_sample(16'h8000);
        send_sample(16'h7FFF);
        send_sample(16'h8000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.iEnable      = 1'b0;
        bus.iStart       = 1'b0;
        bus.iOrder       = '0;
        bus.iRiceParam   = '0;
        bus.iBlockSize   = '0;
        bus.iSample      = '0;
        bus.iSampleValid = 1'b0;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n       = 1'b1;
        bus.iEnable = 1'b1;

        // Order 0, k=0: u = 0,1,2 -> bits 1 01 001
        push_exp(16'd0, 16'hA400);
        start_block(3'd0, 4'd0, 16'd3);
        send_sample(16'h0000);
        send_sample(16'hFFFF);
        send_sample(16'h0001);
        wait_done();

        // Order 2, k=2: two warm-up words, then residual 0 -> bits 100
        push_exp(16'd0, 16'h0064);
        push_exp(16'd1, 16'h00C8);
        push_exp(16'd2, 16'h8000);
        start_block(3'd2, 4'd2, 16'd3);
        send_sample(16'd100);
        send_sample(16'd200);
        send_sample(16'd300);
        wait_done();

        // Order 0, k=0, sample 20: u = 40 -> 40 zeros then a one
        push_exp(16'd0, 16'h0000);
        push_exp(16'd1, 16'h0000);
        push_exp(16'd2, 16'h0080);
        start_block(3'd0, 4'd0, 16'd1);
        send_sample(16'd20);
        wait_done();

        // Order 4, k=14 worst-case residual: q = 63, b = 0x3FEF
        push_order4_image();
        start_block(3'd4, 4'd14, 16'd5);
        send_order4_samples();
        wait_done();

        // Same block with iEnable low for 5 cycles during UNARY
        push_order4_image();
        start_block(3'd7, 4'd15, 16'd5);
        send_order4_samples();
        @(posedge clk); #1;
        bus.iEnable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_write_while_disabled", 32'(bus.oWriteEnable), 32'd0);
        end
        @(posedge clk); #1;
        bus.iEnable = 1'b1;
        wait_done();

        // Reset during UNARY, right after the first residual word is written
        push_order4_image();
        start_block(3'd4, 4'd14, 16'd5);
        send_order4_samples();
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_outputs_zero("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        push_exp(16'd0, 16'hA400);
        start_block(3'd0, 4'd0, 16'd3);
        send_sample(16'h0000);
        send_sample(16'hFFFF);
        send_sample(16'h0001);
        wait_done();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
